// File: rtl/spart_rx.sv
// SPART receive engine: 8N1 deserializer driven by the 16x oversample enable,
// with a one-byte receive buffer and data-available / framing / overrun flags.
module spart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_baud,
   input  logic                 rxd,
   input  logic                 rx_rd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rda,
   output logic                 framing_err,
   output logic                 overrun
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e                 state_q, state_d;
   logic                   rxd_meta_q, rxd_meta_d;
   logic                   rxs_q, rxs_d;
   logic                   rxs_prev_q, rxs_prev_d;
   logic [TICK_W-1:0]      tick_q, tick_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rda_q, rda_d;
   logic                   framing_err_q, framing_err_d;
   logic                   overrun_q, overrun_d;

   logic start_edge;
   logic mid_tick;
   logic end_tick;
   logic load;

   // A start edge needs a high-to-low transition, so a held-low break line
   // cannot re-trigger until it has returned high.
   assign start_edge = rxs_prev_q & ~rxs_q;
   assign mid_tick   = rx_baud && (tick_q == TICK_MID);
   assign end_tick   = rx_baud && (tick_q == TICK_END);
   assign load       = (state_q == STOP) && end_tick;

   // ---------------------------------------------------------------- state register
   // NOTE: sequential blocks use non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next-state logic
   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_edge) state_d = START;
         START: if (mid_tick)   state_d = rxs_q ? IDLE : DATA;
         DATA:  if (end_tick && (bit_q == BIT_LAST)) state_d = STOP;
         STOP:  if (end_tick)   state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- output / datapath logic
   always_comb begin
      rxd_meta_d    = rxd;
      rxs_d         = rxd_meta_q;
      rxs_prev_d    = rxs_q;
      tick_d        = tick_q;
      bit_d         = bit_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rda_d         = rda_q;
      framing_err_d = framing_err_q;
      overrun_d     = overrun_q;

      unique case (state_q)
         IDLE: begin
            tick_d = '0;
            bit_d  = '0;
         end
         START: begin
            bit_d = '0;
            if (mid_tick) begin
               tick_d = '0;
            end else if (rx_baud) begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         DATA: begin
            if (end_tick) begin
               tick_d  = '0;
               bit_d   = bit_q + BIT_W'(1);
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
            end else if (rx_baud) begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         STOP: begin
            if (end_tick) begin
               tick_d = '0;
            end else if (rx_baud) begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         default: begin
            tick_d = '0;
            bit_d  = '0;
         end
      endcase

      // A completing byte always overwrites the buffer and beats a same-cycle pop.
      if (load) begin
         rx_data_d     = shift_q;
         rda_d         = 1'b1;
         framing_err_d = ~rxs_q;
         overrun_d     = rda_q & ~rx_rd;
      end else if (rx_rd && rda_q) begin
         rda_d         = 1'b0;
         framing_err_d = 1'b0;
         overrun_d     = 1'b0;
      end
   end

   // ---------------------------------------------------------------- datapath registers
   // Synchronizer and edge-history flops reset to the idle-high line level so
   // reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta_q    <= 1'b1;
         rxs_q         <= 1'b1;
         rxs_prev_q    <= 1'b1;
         tick_q        <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rda_q         <= 1'b0;
         framing_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         rxd_meta_q    <= rxd_meta_d;
         rxs_q         <= rxs_d;
         rxs_prev_q    <= rxs_prev_d;
         tick_q        <= tick_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rda_q         <= rda_d;
         framing_err_q <= framing_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rda         = rda_q;
   assign framing_err = framing_err_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed testbench for spart_rx: hand-built 8N1 frames on a 20-clk baud
// enable, checking buffer contents, flags, latency and reset behaviour.
`timescale 1ns/1ps
module tb_spart_rx;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;
   localparam int BAUD_DIV   = 20;
   localparam int BIT_CLKS   = OVERSAMPLE * BAUD_DIV;  // 320 clks per bit
   localparam int FRAME_CLKS = 10 * BIT_CLKS;
   // Start edge lands half a clk after a baud pulse: the sync delay is absorbed
   // before the next pulse, so rda rises exactly (1 + 8 + 0.5) bit periods later.
   localparam int RDA_LAT    = 3040;

   logic                 clk;
   logic                 rst_n;
   logic                 rx_baud;
   logic                 rxd;
   logic                 rx_rd;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rda;
   logic                 framing_err;
   logic                 overrun;

   int n_checks;
   int n_errors;
   int cyc;
   int start_cyc;
   int rise_cyc;
   int rda_rises;
   int rises0;
   logic rda_prev;

   spart_rx #(
      .DATA_BITS  (DATA_BITS),
      .OVERSAMPLE (OVERSAMPLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_baud     (rx_baud),
      .rxd         (rxd),
      .rx_rd       (rx_rd),
      .rx_data     (rx_data),
      .rda         (rda),
      .framing_err (framing_err),
      .overrun     (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Baud generator: one-clk pulse every BAUD_DIV clks, changed on negedges.
   initial begin
      rx_baud = 1'b0;
      forever begin
         repeat (BAUD_DIV - 1) @(negedge clk);
         rx_baud = 1'b1;
         @(negedge clk);
         rx_baud = 1'b0;
      end
   end

   // rda rise monitor, sampled on the inactive edge.
   initial begin
      rda_rises = 0;
      rise_cyc  = 0;
      rda_prev  = 1'b0;
      forever begin
         @(negedge clk);
         if (rda && !rda_prev) begin
            rda_rises++;
            rise_cyc = cyc;
         end
         rda_prev = rda;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic align_to_baud();
      do @(posedge clk); while (!rx_baud);
      @(negedge clk);
   endtask

   // Drives n_clks clks of one frame starting half a clk after a baud pulse;
   // rx_rd pulses on the negedge at offset rd_off (-1 for none).
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input int rd_off, input int n_clks);
      logic [9:0] fb;
      fb = {stop_bit, data, 1'b0};
      align_to_baud();
      start_cyc = cyc;
      for (int k = 0; k < n_clks; k++) begin
         rxd   = fb[k / BIT_CLKS];
         rx_rd = (k == rd_off);
         @(negedge clk);
      end
      rx_rd = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      rxd      = 1'b1;
      rx_rd    = 1'b0;
      #23;
      check("rst_rda",  32'(rda),         32'd0);
      check("rst_data", 32'(rx_data),     32'h00);
      check("rst_fe",   32'(framing_err), 32'd0);
      check("rst_ovr",  32'(overrun),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(BIT_CLKS);

      // Plain frame, latency and pop
      rises0 = rda_rises;
      send_frame(8'h55, 1'b1, -1, FRAME_CLKS);
      idle(1);
      check("f55_rda",   32'(rda),              32'd1);
      check("f55_data",  32'(rx_data),          32'h55);
      check("f55_fe",    32'(framing_err),      32'd0);
      check("f55_ovr",   32'(overrun),          32'd0);
      check("f55_lat",   32'(rise_cyc - start_cyc), 32'(RDA_LAT));
      check("f55_rises", 32'(rda_rises - rises0),   32'd1);
      pop();
      check("f55_pop_rda",  32'(rda),     32'd0);
      check("f55_pop_data", 32'(rx_data), 32'h55);

      // Short low glitch is a false start
      rises0 = rda_rises;
      align_to_baud();
      rxd = 1'b0;
      idle(4 * BAUD_DIV);
      rxd = 1'b1;
      idle(2 * BIT_CLKS);
      check("glitch_rda",   32'(rda),                 32'd0);
      check("glitch_rises", 32'(rda_rises - rises0),  32'd0);
      check("glitch_data",  32'(rx_data),             32'h55);
      send_frame(8'hA3, 1'b1, -1, FRAME_CLKS);
      idle(1);
      check("fA3_rda",  32'(rda),         32'd1);
      check("fA3_data", 32'(rx_data),     32'hA3);
      check("fA3_fe",   32'(framing_err), 32'd0);
      pop();

      // Stop bit low -> framing error
      send_frame(8'h3C, 1'b0, -1, FRAME_CLKS);
      rxd = 1'b1;
      idle(BIT_CLKS);
      check("f3C_rda",  32'(rda),         32'd1);
      check("f3C_data", 32'(rx_data),     32'h3C);
      check("f3C_fe",   32'(framing_err), 32'd1);
      check("f3C_ovr",  32'(overrun),     32'd0);
      pop();
      check("f3C_pop_rda", 32'(rda),         32'd0);
      check("f3C_pop_fe",  32'(framing_err), 32'd0);

      // Overrun, then break
      send_frame(8'h11, 1'b1, -1, FRAME_CLKS);
      idle(1);
      check("f11_ovr", 32'(overrun), 32'd0);
      send_frame(8'h22, 1'b1, -1, FRAME_CLKS);
      idle(1);
      check("f22_rda",  32'(rda),         32'd1);
      check("f22_data", 32'(rx_data),     32'h22);
      check("f22_ovr",  32'(overrun),     32'd1);
      check("f22_fe",   32'(framing_err), 32'd0);
      pop();
      check("f22_pop_ovr", 32'(overrun), 32'd0);
      rises0 = rda_rises;
      @(negedge clk);
      rxd = 1'b0;
      idle(20 * BIT_CLKS);
      rxd = 1'b1;
      idle(2 * BIT_CLKS);
      check("brk_rises", 32'(rda_rises - rises0), 32'd1);
      check("brk_data",  32'(rx_data),            32'h00);
      check("brk_fe",    32'(framing_err),        32'd1);
      check("brk_ovr",   32'(overrun),            32'd0);
      pop();

      // Pop on the exact load cycle of a second byte
      send_frame(8'h5A, 1'b1, -1, FRAME_CLKS);
      send_frame(8'h7E, 1'b1, RDA_LAT - 1, FRAME_CLKS);
      idle(1);
      check("f7E_rda",  32'(rda),         32'd1);
      check("f7E_data", 32'(rx_data),     32'h7E);
      check("f7E_ovr",  32'(overrun),     32'd0);
      check("f7E_fe",   32'(framing_err), 32'd0);

      // Async reset mid-data, then a clean frame
      send_frame(8'hC8, 1'b1, -1, 1000);
      #2;
      rst_n = 1'b0;
      rxd   = 1'b1;
      #1;
      check("mid_rst_rda",  32'(rda),         32'd0);
      check("mid_rst_data", 32'(rx_data),     32'h00);
      check("mid_rst_fe",   32'(framing_err), 32'd0);
      check("mid_rst_ovr",  32'(overrun),     32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(BIT_CLKS);
      check("post_rst_rda", 32'(rda), 32'd0);
      send_frame(8'hC8, 1'b1, -1, FRAME_CLKS);
      idle(1);
      check("fC8_rda",  32'(rda),         32'd1);
      check("fC8_data", 32'(rx_data),     32'hC8);
      check("fC8_fe",   32'(framing_err), 32'd0);
      check("fC8_ovr",  32'(overrun),     32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
Serial receive engine for the SPART. It consumes the 16x-oversample enable pulse from the baud generator and deserializes the asynchronous rxd line (8N1, LSB first) into a one-byte receive buffer. It flags data-available, framing error and overrun to the bus interface, which pops the buffer with a one-cycle read strobe.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first); no parity.
OVERSAMPLE, 16, rx_baud pulses per bit period; must be even, >= 4.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_baud  input  1  one-clk enable pulse, OVERSAMPLE per bit period (baud generator receive_baud)
rxd  input  1  asynchronous serial input, idle high
rx_rd  input  1  one-clk pop strobe from bus interface
rx_data  output  DATA_BITS  receive buffer, last completed byte
rda  output  1  receive data available
framing_err  output  1  stop bit of buffered byte sampled low
overrun  output  1  a byte completed while rda was set and not being popped

Behaviour:
- Reset (async, active-low, any time incl. mid-frame): state IDLE, tick/bit counters 0, shift reg 0, rx_data 0, rda 0, framing_err 0, overrun 0, both rxd sync flops 1, edge-history flop 1.
- rxd passes through a 2-flop synchronizer; all decisions use the synced value (rxs). Edge history flop holds the previous rxs.
- Tick counter (log2(OVERSAMPLE) bits) advances only on clk edges with rx_baud=1; no state advances without rx_baud except IDLE start detection.
- IDLE: falling edge (prev rxs=1, rxs=0) -> START, tick=0. A line held low (break) never re-triggers until it returns high.
- START: on the rx_baud pulse where tick = OVERSAMPLE/2-1 (mid start bit): rxs=0 -> DATA, tick=0, bit=0; rxs=1 -> IDLE (false start, no flags change).
- DATA: on the rx_baud pulse where tick = OVERSAMPLE-1: shift rxs into MSB of shift reg (right shift), tick=0, bit+1; after the DATA_BITS-th sample -> STOP.
- STOP: on the rx_baud pulse where tick = OVERSAMPLE-1: load rx_data <= shift reg, rda <= 1, framing_err <= ~rxs, overrun <= (rda & ~rx_rd); -> IDLE. New byte always overwrites buffer.
- Latency: rda rises the clk after the mid-stop-bit sample, i.e. (1 + DATA_BITS + 0.5) bit periods + sync delay (2 clk) after the rxd falling edge.
- rx_rd without a same-cycle load: next clk rda, framing_err, overrun <= 0; rx_data holds its value.
- rx_rd coincident with load: load wins; rda=1, framing_err per new stop bit, overrun=0.
- rx_rd while rda=0: no effect.
- rx_baud or rx_rd asserted for multiple consecutive clks are each treated as separate events.
- Receiving continues regardless of rda; no backpressure on the line.

Test Plan:
- Frame 0x55, stop=1, rx_baud every 20 clks -> one rda rise ~9.5 bit periods after start edge; rx_data=0x55, framing_err=0, overrun=0; rx_rd -> rda=0 next clk, rx_data still 0x55.
- rxd low glitch lasting 4 rx_baud pulses then high -> returns to IDLE, rda stays 0; following valid frame 0xA3 received as 0xA3.
- Frame 0x3C with stop bit 0, then line high -> rda=1, rx_data=0x3C, framing_err=1; rx_rd clears both flags.
- Frames 0x11 then 0x22 without rx_rd -> after second: rx_data=0x22, rda=1, overrun=1; line held low 20 bit times (break) -> exactly one framing-error byte 0x00, no repeated triggers.
- rx_rd asserted on the exact clk the second byte 0x7E loads -> rda=1, rx_data=0x7E, overrun=0.
- rst_n pulsed low mid-DATA of a frame -> all outputs 0 immediately; state IDLE; next full frame 0xC8 received correctly.
